radar_serial_tx: RTL and testbench

- Bench-side radar emulator that drives the AGC radar serial inputs (RRIN0/RRIN1 or LRIN0/LRIN1).
- Responds to the AGC sync pulses (RRSYNC/LRSYNC) and the word-select lines (RRRANG/RRRARA, or LRXVEL/LRYVEL/LRZVEL/LRRANG).
- Each sync pulse returns one bit of a 15-bit word, MSB first, as a dual-rail pulse.
- Instantiated once per radar in module testbenches and system sims, alongside the I/O module that receives the data.

---
 rtl/radar_pkg.sv | 29 ++
 rtl/radar_serial_tx_chk.sv | 21 ++
 rtl/radar_sync_edge.sv | 42 ++++
 rtl/radar_serial_tx.sv | 238 +++++++++++++++++++++++
 tb/tb_radar_serial_tx.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/radar_pkg.sv
// -----------------------------------------------------------------------------
// radar_pkg
// Shared definitions for the AGC radar serial emulator: radar word width,
// word-select indices for the rendezvous and landing radars, and the
// serializer state encoding.
// -----------------------------------------------------------------------------
package radar_pkg;

    // Every radar word is 15 bits, shifted out MSB first
    localparam int WORD_W = 15;

    // Rendezvous radar word selects (RRRANG / RRRARA)
    localparam int RR_RANG = 0;
    localparam int RR_RARA = 1;

    // Landing radar word selects (LRXVEL / LRYVEL / LRZVEL / LRRANG)
    localparam int LR_XVEL = 0;
    localparam int LR_YVEL = 1;
    localparam int LR_ZVEL = 2;
    localparam int LR_RANG = 3;

    // Serializer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } radar_state_e;

endpackage

// File: rtl/radar_serial_tx_chk.sv
// -----------------------------------------------------------------------------
// radar_serial_tx_chk
// Property checker for the radar serializer outputs: the zero rail and the
// one rail must never be high at the same time.
//
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset (disables the check)
//   in0 - zero-bit rail
//   in1 - one-bit rail
// -----------------------------------------------------------------------------
module radar_serial_tx_chk (
    input logic clk,
    input logic rst,
    input logic in0,
    input logic in1
);

    rails_exclusive: assert property (@(posedge clk) disable iff (rst) !(in0 && in1));

endmodule

// File: rtl/radar_sync_edge.sv
// -----------------------------------------------------------------------------
// radar_sync_edge
// Synchronous rising-edge detector for a level strobe. The detected edge is
// registered (one clock of latency). When the consumer raises 'hold' in the
// cycle an edge is presented, the edge is re-presented on the next cycle so a
// consumer that is momentarily busy does not lose it.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   strobe - level input sampled on clk
//   hold   - keep the currently presented edge for one more cycle
//   rise   - one-cycle edge indication (or held edge)
// -----------------------------------------------------------------------------
module radar_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    input  logic hold,
    output logic rise
);

    logic prev_r;
    logic edge_r;
    logic pend_r;

    // Previous-sample register, registered edge and one-deep pending hold
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b0;
            edge_r <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            prev_r <= strobe;
            edge_r <= strobe & ~prev_r;
            pend_r <= edge_r & hold;
        end
    end

    assign rise = edge_r | pend_r;

endmodule

// File: rtl/radar_serial_tx.sv
// -----------------------------------------------------------------------------
// radar_serial_tx
// Bench-side radar emulator feeding the AGC radar serial inputs. Each AGC sync
// edge returns one bit of the selected 15-bit word, MSB first, as a pulse on
// IN1 (bit = 1) or IN0 (bit = 0). The word is snapshotted from a small table
// at the first sync of a word; a long silence mid-word aborts the burst.
//
// Ports:
//   CLOCK   - system clock, rising edge
//   rst     - synchronous active-high reset
//   SYNC    - AGC sync strobe (level)
//   SEL     - one-hot word select, sampled at word start only
//   LD_WE   - word table write enable
//   LD_IDX  - word table write index (indices >= NWORDS ignored)
//   LD_DATA - word table write data
//   IN0     - zero-bit pulse to AGC
//   IN1     - one-bit pulse to AGC
//   BUSY    - a word is in progress
//   DONE    - one-clock pulse after the last bit's pulse ends
//   ABORT   - one-clock pulse on gap timeout
//   SELERR  - sticky flag: SEL was not one-hot at a word start
// -----------------------------------------------------------------------------
module radar_serial_tx
    import radar_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 200,
    parameter int NWORDS       = 4
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              SYNC,
    input  logic [NWORDS-1:0] SEL,
    input  logic              LD_WE,
    input  logic [1:0]        LD_IDX,
    input  logic [WORD_W-1:0] LD_DATA,
    output logic              IN0,
    output logic              IN1,
    output logic              BUSY,
    output logic              DONE,
    output logic              ABORT,
    output logic              SELERR
);

    localparam int PCNT_W = $clog2(PULSE_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(GAP_CYCLES);
    localparam logic [3:0]        BIT_LAST  = 4'(WORD_W);

    // True when exactly one bit of the select vector is set
    function automatic logic is_onehot(input logic [NWORDS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NWORDS; i++) begin
            n = n + int'(v[i]);
        end
        return (n == 1);
    endfunction

    logic [WORD_W-1:0] table_r [NWORDS];

    radar_state_e      state_r,  state_nxt_s;
    logic [WORD_W-1:0] shreg_r,  shreg_nxt_s;
    logic [3:0]        bitcnt_r, bitcnt_nxt_s;
    logic [PCNT_W-1:0] pcnt_r,   pcnt_nxt_s;
    logic [GAP_W-1:0]  gap_r,    gap_nxt_s;
    logic              in0_r,    in0_nxt_s;
    logic              in1_r,    in1_nxt_s;
    logic              busy_r,   busy_nxt_s;
    logic              done_r,   done_nxt_s;
    logic              abort_r,  abort_nxt_s;
    logic              selerr_r, selerr_nxt_s;

    logic              rise_s;
    logic              hold_s;
    logic [WORD_W-1:0] sel_word_s;
    logic              sel_ok_s;
    logic [WORD_W-1:0] snap_s;
    logic [GAP_W-1:0]  gap_inc_s;
    logic [3:0]        bitcnt_inc_s;

    radar_sync_edge u_sync_edge (
        .clk    (CLOCK),
        .rst    (rst),
        .strobe (SYNC),
        .hold   (hold_s),
        .rise   (rise_s)
    );

    radar_serial_tx_chk u_chk (
        .clk (CLOCK),
        .rst (rst),
        .in0 (in0_r),
        .in1 (in1_r)
    );

    // Word table: loaded from the write port at any time, cleared by reset
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            for (int i = 0; i < NWORDS; i++) begin
                table_r[i] <= {WORD_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NWORDS; i++) begin
                if (LD_WE && (LD_IDX == 2'(i))) begin
                    table_r[i] <= LD_DATA;
                end
            end
        end
    end

    // Word picked by SEL; the snapshot is zero unless SEL is exactly one-hot
    always_comb begin
        sel_word_s = {WORD_W{1'b0}};
        for (int i = 0; i < NWORDS; i++) begin
            sel_word_s = sel_word_s | (table_r[i] & {WORD_W{SEL[i]}});
        end
        sel_ok_s     = is_onehot(SEL);
        snap_s       = sel_ok_s ? sel_word_s : {WORD_W{1'b0}};
        gap_inc_s    = (gap_r == GAP_LIMIT) ? gap_r : (gap_r + GAP_W'(1));
        bitcnt_inc_s = bitcnt_r + 4'd1;
    end

    // Serializer next-state and next-output logic
    always_comb begin
        state_nxt_s  = state_r;
        shreg_nxt_s  = shreg_r;
        bitcnt_nxt_s = bitcnt_r;
        pcnt_nxt_s   = pcnt_r;
        gap_nxt_s    = gap_r;
        in0_nxt_s    = 1'b0;
        in1_nxt_s    = 1'b0;
        busy_nxt_s   = busy_r;
        done_nxt_s   = 1'b0;
        abort_nxt_s  = 1'b0;
        selerr_nxt_s = selerr_r;
        hold_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    shreg_nxt_s  = snap_s;
                    selerr_nxt_s = selerr_r | ~sel_ok_s;
                    bitcnt_nxt_s = 4'd0;
                    pcnt_nxt_s   = {PCNT_W{1'b0}};
                    busy_nxt_s   = 1'b1;
                    in1_nxt_s    = snap_s[WORD_W-1];
                    in0_nxt_s    = ~snap_s[WORD_W-1];
                    state_nxt_s  = ST_PULSE;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end

            ST_PULSE: begin
                // Sync edges seen here are dropped, except on the final
                // cycle of the word where the edge is held for IDLE.
                if (pcnt_r == PCNT_LAST) begin
                    shreg_nxt_s  = {shreg_r[WORD_W-2:0], 1'b0};
                    bitcnt_nxt_s = bitcnt_inc_s;
                    if (bitcnt_inc_s == BIT_LAST) begin
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                        hold_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        gap_nxt_s   = {GAP_W{1'b0}};
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    pcnt_nxt_s = pcnt_r + PCNT_W'(1);
                    in1_nxt_s  = shreg_r[WORD_W-1];
                    in0_nxt_s  = ~shreg_r[WORD_W-1];
                end
            end

            ST_WAIT: begin
                if (rise_s) begin
                    pcnt_nxt_s  = {PCNT_W{1'b0}};
                    in1_nxt_s   = shreg_r[WORD_W-1];
                    in0_nxt_s   = ~shreg_r[WORD_W-1];
                    state_nxt_s = ST_PULSE;
                end else if (gap_inc_s == GAP_LIMIT) begin
                    gap_nxt_s   = gap_inc_s;
                    abort_nxt_s = 1'b1;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_nxt_s   = gap_inc_s;
                end
            end

            default: begin
                busy_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Serializer state and registered outputs
    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            shreg_r  <= {WORD_W{1'b0}};
            bitcnt_r <= 4'd0;
            pcnt_r   <= {PCNT_W{1'b0}};
            gap_r    <= {GAP_W{1'b0}};
            in0_r    <= 1'b0;
            in1_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            abort_r  <= 1'b0;
            selerr_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            shreg_r  <= shreg_nxt_s;
            bitcnt_r <= bitcnt_nxt_s;
            pcnt_r   <= pcnt_nxt_s;
            gap_r    <= gap_nxt_s;
            in0_r    <= in0_nxt_s;
            in1_r    <= in1_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
            abort_r  <= abort_nxt_s;
            selerr_r <= selerr_nxt_s;
        end
    end

    assign IN0    = in0_r;
    assign IN1    = in1_r;
    assign BUSY   = busy_r;
    assign DONE   = done_r;
    assign ABORT  = abort_r;
    assign SELERR = selerr_r;

endmodule

// File: tb/tb_radar_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_radar_serial_tx
// Self-checking bench for radar_serial_tx. Every sync that should produce a
// bit pushes the expected rail onto a scoreboard queue; a negedge monitor pops
// one entry per observed pulse and also checks pulse width and DONE/ABORT
// timing relative to the end of the preceding pulse.
// -----------------------------------------------------------------------------
module tb_radar_serial_tx;

    localparam int PULSE = 4;
    localparam int GAP   = 200;
    localparam int NW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          sync;
    logic [NW-1:0] sel;
    logic          ld_we;
    logic [1:0]    ld_idx;
    logic [14:0]   ld_data;
    logic          in0, in1, busy, done, abort, selerr;

    always #5 clk = ~clk;

    radar_serial_tx #(
        .PULSE_CYCLES (PULSE),
        .GAP_CYCLES   (GAP),
        .NWORDS       (NW)
    ) dut (
        .CLOCK   (clk),
        .rst     (rst),
        .SYNC    (sync),
        .SEL     (sel),
        .LD_WE   (ld_we),
        .LD_IDX  (ld_idx),
        .LD_DATA (ld_data),
        .IN0     (in0),
        .IN1     (in1),
        .BUSY    (busy),
        .DONE    (done),
        .ABORT   (abort),
        .SELERR  (selerr)
    );

    int          checks = 0;
    int          errors = 0;
    logic        exp_q [$];
    logic [14:0] mdl_tbl [NW];
    logic [14:0] cur_word;
    int          cur_bit;

    int          pulse_cnt = 0;
    int          done_cnt  = 0;
    int          abort_cnt = 0;
    int          since_end = 0;
    int          width     = 0;
    logic        rail_prev = 1'b0;
    logic        rail_now;
    logic        exp_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pulse monitor: scoreboard pop, width, DONE/ABORT timing
    always @(negedge clk) begin
        rail_now = in0 | in1;
        if (rail_now === 1'b1) begin
            if (!rail_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("bit_value", 32'(in1), 32'(exp_b));
                end
                width = 0;
            end
            width++;
            if (in0 && in1) chk("one_rail", 32'd1, 32'd0);
        end else begin
            if (rail_prev) begin
                chk("pulse_width", width, PULSE);
                pulse_cnt++;
                since_end = 0;
            end else begin
                since_end++;
            end
        end
        // since_end is the number of clock edges since the pulse dropped
        if (done === 1'b1) begin
            chk("done_latency", since_end, 32'd0);
            done_cnt++;
        end
        if (abort === 1'b1) begin
            chk("abort_latency", since_end, GAP);
            abort_cnt++;
        end
        rail_prev = (rail_now === 1'b1);
    end

    task automatic load(input int idx, input logic [14:0] d);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_idx  = 2'(idx);
        ld_data = d;
        @(negedge clk);
        ld_we   = 1'b0;
        mdl_tbl[idx] = d;
    endtask

    // Model snapshot of the word the next sync should start
    task automatic start_word();
        cur_word = 15'h0000;
        if ($onehot(sel)) begin
            for (int i = 0; i < NW; i++) begin
                if (sel[i]) cur_word = mdl_tbl[i];
            end
        end
        cur_bit = 14;
    endtask

    task automatic sync_bit();
        exp_q.push_back(cur_word[cur_bit]);
        cur_bit--;
        @(negedge clk);
        sync = 1'b1;
        repeat (2) @(negedge clk);
        sync = 1'b0;
        repeat (18) @(negedge clk);
    endtask

    // One bit whose sync is followed by a second edge landing mid-pulse
    task automatic sync_bit_overlap();
        exp_q.push_back(cur_word[cur_bit]);
        cur_bit--;
        @(negedge clk);
        sync = 1'b1;
        repeat (2) @(negedge clk);
        sync = 1'b0;
        @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        sync    = 1'b0;
        sel     = 4'b0001;
        ld_we   = 1'b0;
        ld_idx  = 2'd0;
        ld_data = 15'h0000;
        for (int i = 0; i < NW; i++) mdl_tbl[i] = 15'h0000;
        repeat (3) @(negedge clk);
        chk("rst_in0", 32'(in0), 32'd0);
        chk("rst_in1", 32'(in1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_selerr", 32'(selerr), 32'd0);
        rst = 1'b0;

        // Full word 5A5A from index 1
        load(1, 15'h5A5A);
        sel = 4'b0010;
        start_word();
        sync_bit();
        chk("t1_busy_mid", 32'(busy), 32'd1);
        repeat (14) sync_bit();
        chk("t1_pulses", pulse_cnt, 32'd15);
        chk("t1_done", done_cnt, 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_queue", exp_q.size(), 32'd0);
        chk("t1_selerr", 32'(selerr), 32'd0);

        // Five bits then silence: abort, then a fresh word from bit 14
        start_word();
        repeat (5) sync_bit();
        repeat (GAP + 20) @(negedge clk);
        chk("t2_abort", abort_cnt, 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_done", done_cnt, 32'd1);
        chk("t2_queue", exp_q.size(), 32'd0);
        load(1, 15'h0001);
        start_word();
        repeat (15) sync_bit();
        chk("t2_restart_done", done_cnt, 32'd2);
        chk("t2_pulses", pulse_cnt, 32'd35);

        // 16 syncs, one landing inside a pulse: still 15 pulses
        load(1, 15'h1234);
        start_word();
        repeat (3) sync_bit();
        sync_bit_overlap();
        repeat (11) sync_bit();
        chk("t3_pulses", pulse_cnt, 32'd50);
        chk("t3_done", done_cnt, 32'd3);

        // Table write and SEL changes mid-burst do not disturb the word
        load(1, 15'h0F0F);
        start_word();
        repeat (4) sync_bit();
        load(1, 15'h7FFF);
        sel = 4'b1000;
        sync_bit();
        sel = 4'b0110;
        sync_bit();
        sel = 4'b0010;
        repeat (9) sync_bit();
        chk("t4_done", done_cnt, 32'd4);
        chk("t4_selerr", 32'(selerr), 32'd0);
        start_word();
        repeat (15) sync_bit();
        chk("t4_next_done", done_cnt, 32'd5);

        // Non-one-hot SEL at word start: zeros and sticky SELERR
        sel = 4'b0110;
        start_word();
        repeat (15) sync_bit();
        chk("t5_selerr", 32'(selerr), 32'd1);
        chk("t5_done", done_cnt, 32'd6);
        sel = 4'b0010;
        start_word();
        repeat (15) sync_bit();
        chk("t5_selerr_sticky", 32'(selerr), 32'd1);

        // Reset mid-burst clears outputs, flags and table
        start_word();
        repeat (7) sync_bit();
        chk("t6_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_in0", 32'(in0), 32'd0);
        chk("t6_in1", 32'(in1), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_selerr", 32'(selerr), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < NW; i++) mdl_tbl[i] = 15'h0000;
        chk("t6_queue", exp_q.size(), 32'd0);
        start_word();
        repeat (15) sync_bit();
        chk("t6_done", done_cnt, 32'd8);
        chk("t6_pulses", pulse_cnt, 32'd132);
        chk("t6_abort", abort_cnt, 32'd1);

        repeat (5) @(negedge clk);
        chk("final_queue", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
